// File: rtl/vr_rr_arbiter.sv
// Shares one valid/ready sink among NUM_SRC sources, one beat per grant, round-robin or fixed priority.
// Latency: request to snk_valid 1 cycle, at most one beat per 2 cycles; a stalled sink holds the grant (never preempted).
module vr_rr_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int IDX_BITS    = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mode,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic                           snk_valid,
  output logic [DATA_WIDTH-1:0]          snk_data,
  input  logic                           snk_ready,
  output logic [IDX_BITS-1:0]            grant_idx,
  output logic                           busy,
  output logic [COUNT_WIDTH-1:0]         xfer_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]            state;
  logic [IDX_BITS-1:0]   last_ptr;
  logic [IDX_BITS-1:0]   rr_idx;
  logic [IDX_BITS-1:0]   fp_idx;
  logic [IDX_BITS-1:0]   hi_idx;
  logic                  hi_found;
  logic [IDX_BITS-1:0]   win_idx;
  logic                  any_valid;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  handshake;

  // Round-robin: first requester above last_ptr, otherwise wrap to the lowest requester.
  always_comb begin
    fp_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        fp_idx = IDX_BITS'(i);
        if (IDX_BITS'(i) > last_ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_BITS'(i);
        end
      end
    end
    rr_idx = hi_found ? hi_idx : fp_idx;
  end

  assign any_valid = |src_valid;
  assign win_idx   = mode ? fp_idx : rr_idx;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == IDX_BITS'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy      = (state == BUSY);
  assign snk_valid = busy & sel_valid;
  assign snk_data  = busy ? sel_data : '0;
  assign handshake = busy & sel_valid & snk_ready;

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = busy && (grant_idx == IDX_BITS'(i)) && snk_ready;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_ptr   <= IDX_BITS'(NUM_SRC - 1);
      xfer_count <= '0;
    end else if (state == IDLE) begin
      if (any_valid) begin
        grant_idx <= win_idx;
        state     <= BUSY;
      end
    end else begin
      if (handshake) begin
        last_ptr   <= grant_idx;
        xfer_count <= xfer_count + COUNT_WIDTH'(1);
        state      <= IDLE;
      end else if (!sel_valid) begin
        // Source withdrew its request: release the grant without counting a beat.
        state <= IDLE;
      end
    end
  end

endmodule

// File: doc/vr_rr_arbiter.md
Name: vr_rr_arbiter

Overview:
- Shares one valid/ready sink (e.g. the delayed-ready sink stage) among NUM_SRC valid/ready sources.
- Grants one source at a time, one beat per grant. Grant order is round-robin or fixed-priority.
- Sits between the source stages and the sink. It is transparent on data: no buffering, no modification.
- Also provides a transfer counter and grant status for debug and test.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_WIDTH, 8, data bits per source and on the sink side.
- IDX_BITS, 2, width of grant index; must be ≥ clog2(NUM_SRC).
- COUNT_WIDTH, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  0 = round-robin, 1 = fixed priority (src 0 highest).
- src_valid  input  NUM_SRC  per-source valid.
- src_data  input  NUM_SRC*DATA_WIDTH  flattened source data; src i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_ready  output  NUM_SRC  per-source ready.
- snk_valid  output  1  valid to sink.
- snk_data  output  DATA_WIDTH  data to sink.
- snk_ready  input  1  ready from sink.
- grant_idx  output  IDX_BITS  index of the granted source; meaningful only while busy=1.
- busy  output  1  1 while a grant is held.
- xfer_count  output  COUNT_WIDTH  completed handshakes, wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, grant_idx = 0, busy = 0, last_ptr = NUM_SRC-1, xfer_count = 0.
  - snk_valid = 0, snk_data = 0, src_ready = all 0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - busy = 0, snk_valid = 0, snk_data = 0, src_ready = 0.
  - At a clock edge, if any src_valid is 1: register winner into grant_idx, go to BUSY.
  - If no src_valid is 1, stay in IDLE.
  - mode is sampled only here.
- Winner selection:
  - mode=0: first asserted src_valid searching from last_ptr+1 upward, wrapping modulo NUM_SRC.
  - mode=1: lowest asserted index.
- BUSY (combinational outputs):
  - busy = 1.
  - snk_valid = src_valid[grant_idx].
  - snk_data = src_data[grant_idx].
  - src_ready[grant_idx] = snk_ready; all other src_ready = 0.
- BUSY, handshake (src_valid[grant_idx] & snk_ready at an edge):
  - last_ptr <= grant_idx (both modes).
  - xfer_count <= xfer_count + 1.
  - Go to IDLE.
- BUSY, granted source drops valid without handshake (protocol violation):
  - Go to IDLE next edge.
  - No count; last_ptr unchanged.
- Grant is never preempted. New or higher-priority requests during BUSY are ignored until return to IDLE.
- Latency:
  - Request to snk_valid: 1 cycle (IDLE edge).
  - Minimum 2 cycles per beat; maximum throughput is 1 beat per 2 cycles.
  - IDLE after a handshake is mandatory, even with requests pending.
- Fairness, mode=0, all sources continuously valid: each source granted exactly once per NUM_SRC grants.
- xfer_count wraps to 0 after 2^COUNT_WIDTH-1; no saturation.
- Reset asserted mid-BUSY: all outputs return to reset values immediately. The in-flight beat is dropped and not counted.
- grant_idx holds its last value in IDLE. Verification must not check it unless busy=1.

Test Plan:
- Single source 2 valid, data 0x11, snk_ready=1, mode=0: busy and grant_idx=2 one cycle after valid; snk_data=0x11; src_ready[2]=1 that cycle; xfer_count=1; then IDLE for 1 cycle.
- All 4 sources continuously valid, snk_ready=1, mode=0: grant order 0,1,2,3,0,1; each handshake 2 cycles apart; xfer_count=6 after 12 cycles.
- Same stimulus with mode=1: grant_idx always 0; src_ready[1..3] never 1.
- src1 granted, snk_ready=0 for 5 cycles, src0 raises valid at cycle 2: snk_data stays src1's data, grant_idx stays 1; after ready, handshake completes, next grant = 2 if valid, else 3, else 0 (search starts after 1).
- Reset pulsed low while BUSY on src3: snk_valid=0, busy=0, xfer_count=0 during reset; first grant after release with all sources valid = src0.
- COUNT_WIDTH=4, 17 single-source transfers: xfer_count reads 15, 0, 1 across the last three.
- Granted src2 deasserts valid before snk_ready: return to IDLE; xfer_count unchanged; next grant with src2 and src3 valid = src3.
